// File: rtl/game_pkg.sv
// Shared types and default constants for the game board controller.
// Imported by edge_detect and game_ctrl.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED  = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } game_state_t;

  localparam int GEN_W_DEF       = 16;
  localparam int DIV_W_DEF       = 24;
  localparam int SEED_CYCLES_DEF = 64;

  // Button bit positions inside the edge detector vector
  localparam int B_START = 0;
  localparam int B_RAND  = 1;
  localparam int B_PAUSE = 2;
  localparam int B_STEP  = 3;

endpackage

// File: rtl/edge_detect.sv
// Per-bit rising-edge pulse generator with one history register per bit.
// Ports: clk, reset (sync active-low), in_i[N], pulse_o[N] (combinational).
module edge_detect
  import game_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_i,
  output logic [N-1:0] pulse_o
);

  logic [N-1:0] prev_q;

  // History resets high so a button held through reset gives no edge
  always_ff @(posedge clk) begin
    if (!reset) prev_q <= '1;
    else        prev_q <= in_i;
  end

  assign pulse_o = in_i & ~prev_q;

endmodule

// File: rtl/game_ctrl.sv
// Board sequencer: clear, seed, play, pause/step, generation-limit stop.
// Ports: buttons in, speed/max_gen config, Moore flags, advance pulse, gen_count, state_o.
module game_ctrl
  import game_pkg::*;
#(
  parameter int GEN_W       = GEN_W_DEF,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int SEED_CYCLES = SEED_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             randomize,
  input  logic             pause,
  input  logic             step,
  input  logic             clear,
  input  logic [DIV_W-1:0] speed,
  input  logic [GEN_W-1:0] max_gen,
  output logic             clr,
  output logic             rnd_en,
  output logic             advance,
  output logic             running,
  output logic             done,
  output logic [GEN_W-1:0] gen_count,
  output logic [2:0]       state_o
);

  localparam int SW = (SEED_CYCLES > 1) ? $clog2(SEED_CYCLES) : 1;
  localparam logic [SW-1:0] SEED_LAST = SW'(SEED_CYCLES - 1);

  game_state_t      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [SW-1:0]    seed_q, seed_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             adv_q, adv_d;

  logic [3:0] btn, btn_p;
  logic       start_p, rand_p, pause_p, step_p;
  logic [GEN_W-1:0] gen_inc;

  assign btn = {step, pause, randomize, start};

  edge_detect #(.N(4)) u_edge (
    .clk     (clk),
    .reset   (reset),
    .in_i    (btn),
    .pulse_o (btn_p)
  );

  assign start_p = btn_p[B_START];
  assign rand_p  = btn_p[B_RAND];
  assign pause_p = btn_p[B_PAUSE];
  assign step_p  = btn_p[B_STEP];

  // Saturating increment
  assign gen_inc = (gen_q == '1) ? gen_q : gen_q + 1'b1;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    seed_d  = seed_q;
    gen_d   = gen_q;
    adv_d   = 1'b0;
    if (clear) begin
      state_d = IDLE;
      div_d   = '0;
    end else if (rand_p) begin
      // Also restarts an in-progress seeding pass
      state_d = SEED;
      seed_d  = '0;
      gen_d   = '0;
      div_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start_p) begin
            state_d = PLAY;
            gen_d   = '0;
            div_d   = '0;
          end
        end
        SEED: begin
          if (seed_q == SEED_LAST) begin
            state_d = PAUSE;
            seed_d  = '0;
          end else begin
            seed_d = seed_q + 1'b1;
          end
        end
        PLAY: begin
          if (pause_p) begin
            state_d = PAUSE;
          end else if (div_q >= speed) begin
            // >= keeps us moving if speed was lowered below div
            adv_d = 1'b1;
            div_d = '0;
            gen_d = gen_inc;
            if (max_gen != '0 && gen_inc == max_gen) state_d = DONE;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        PAUSE: begin
          if (start_p || pause_p) begin
            state_d = PLAY;
          end else if (step_p) begin
            adv_d = 1'b1;
            gen_d = gen_inc;
            if (max_gen != '0 && gen_inc == max_gen) state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      seed_q  <= '0;
      gen_q   <= '0;
      adv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      seed_q  <= seed_d;
      gen_q   <= gen_d;
      adv_q   <= adv_d;
    end
  end

  assign clr       = (state_q == IDLE);
  assign rnd_en    = (state_q == SEED);
  assign running   = (state_q == PLAY);
  assign done      = (state_q == DONE);
  assign advance   = adv_q;
  assign gen_count = gen_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed testbench for game_ctrl.
// Runs scenario tasks in sequence and prints one summary line.
module tb_game_ctrl;
  import game_pkg::*;

  localparam int GW = 16;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          reset, start, randomize, pause, step, clear;
  logic [DW-1:0] speed;
  logic [GW-1:0] max_gen;
  logic          clr, rnd_en, advance, running, done;
  logic [GW-1:0] gen_count;
  logic [2:0]    state_o;

  int n_tests = 0;
  int n_fail  = 0;

  game_ctrl #(.GEN_W(GW), .DIV_W(DW), .SEED_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .randomize (randomize),
    .pause     (pause),
    .step      (step),
    .clear     (clear),
    .speed     (speed),
    .max_gen   (max_gen),
    .clr       (clr),
    .rnd_en    (rnd_en),
    .advance   (advance),
    .running   (running),
    .done      (done),
    .gen_count (gen_count),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    n_tests++;
    if ({clr, rnd_en, advance, running, done} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 10000",
               {clr, rnd_en, advance, running, done});
    end
    n_tests++;
    if (gen_count !== 16'd0 || state_o !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state got st=%0d gen=%0d exp st=0 gen=0",
               state_o, gen_count);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++;
      if (state_o !== IDLE || advance !== 1'b0 || clr !== 1'b1) begin
        n_fail++;
        $display("FAIL held_start cyc %0d got st=%0d adv=%b exp st=0 adv=0",
                 i, state_o, advance);
      end
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_seed();
    int cnt;
    int guard;
    randomize = 1'b1;
    tick();
    randomize = 1'b0;
    cnt = 0; guard = 0;
    while (rnd_en === 1'b1 && guard < 20) begin
      cnt++; guard++;
      tick();
    end
    n_tests++;
    if (cnt != 4) begin
      n_fail++;
      $display("FAIL seed_len got %0d exp 4", cnt);
    end
    n_tests++;
    if (state_o !== PAUSE || gen_count !== 16'd0) begin
      n_fail++;
      $display("FAIL seed_end got st=%0d gen=%0d exp st=3 gen=0",
               state_o, gen_count);
    end
  endtask

  task automatic test_play();
    speed = 24'd3; max_gen = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if (running !== 1'b1) begin
      n_fail++;
      $display("FAIL play_enter got running=%b exp 1", running);
    end
    for (int c = 1; c <= 12; c++) begin
      tick();
      n_tests++;
      if (advance !== ((c % 4) == 0)) begin
        n_fail++;
        $display("FAIL play_adv cyc %0d got %b exp %b",
                 c, advance, (c % 4) == 0);
      end
      if (c % 4 == 0) begin
        n_tests++;
        if (gen_count !== 16'(c / 4)) begin
          n_fail++;
          $display("FAIL play_gen cyc %0d got %0d exp %0d",
                   c, gen_count, c / 4);
        end
      end
    end
  endtask

  task automatic test_pause_step();
    int advs;
    pause = 1'b1;
    tick();
    pause = 1'b0;
    n_tests++;
    if (state_o !== PAUSE || advance !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_enter got st=%0d adv=%b exp st=3 adv=0",
               state_o, advance);
    end
    advs = 0;
    for (int i = 0; i < 25; i++) begin
      step = (i == 0 || i == 10);
      tick();
      if (advance === 1'b1) advs++;
    end
    step = 1'b0;
    n_tests++;
    if (advs != 2) begin
      n_fail++;
      $display("FAIL step_count got %0d exp 2", advs);
    end
    n_tests++;
    if (gen_count !== 16'd5 || state_o !== PAUSE) begin
      n_fail++;
      $display("FAIL step_gen got gen=%0d st=%0d exp gen=5 st=3",
               gen_count, state_o);
    end
    pause = 1'b1;
    tick();
    pause = 1'b0;
    n_tests++;
    if (running !== 1'b1) begin
      n_fail++;
      $display("FAIL resume got running=%b exp 1", running);
    end
  endtask

  task automatic test_maxgen();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_tests++;
    if (state_o !== IDLE || clr !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_idle got st=%0d exp 0", state_o);
    end
    speed = 24'd0; max_gen = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_tests++;
      if (advance !== 1'b1 || gen_count !== 16'(i)) begin
        n_fail++;
        $display("FAIL maxgen_adv %0d got adv=%b gen=%0d exp adv=1 gen=%0d",
                 i, advance, gen_count, i);
      end
    end
    n_tests++;
    if (done !== 1'b1 || state_o !== DONE) begin
      n_fail++;
      $display("FAIL maxgen_done got done=%b st=%0d exp 1 4", done, state_o);
    end
    pause = 1'b1;
    tick();
    pause = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (advance !== 1'b0 || gen_count !== 16'd5 || state_o !== DONE) begin
        n_fail++;
        $display("FAIL done_hold %0d got adv=%b gen=%0d st=%0d exp 0 5 4",
                 i, advance, gen_count, state_o);
      end
      tick();
    end
  endtask

  task automatic test_speed_drop();
    speed = 24'd10; max_gen = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    speed = 24'd2;
    tick();
    n_tests++;
    if (advance !== 1'b1 || gen_count !== 16'd1) begin
      n_fail++;
      $display("FAIL speed_drop got adv=%b gen=%0d exp 1 1",
               advance, gen_count);
    end
    tick();
    n_tests++;
    if (advance !== 1'b0) begin
      n_fail++;
      $display("FAIL speed_drop_next got %b exp 0", advance);
    end
  endtask

  task automatic test_clear_reset();
    clear = 1'b1; randomize = 1'b1;
    tick();
    clear = 1'b0; randomize = 1'b0;
    n_tests++;
    if (state_o !== IDLE || rnd_en !== 1'b0 || clr !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_prio got st=%0d rnd=%b exp st=0 rnd=0",
               state_o, rnd_en);
    end
    n_tests++;
    if (gen_count !== 16'd1) begin
      n_fail++;
      $display("FAIL clear_keep_gen got %0d exp 1", gen_count);
    end
    speed = 24'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    n_tests++;
    if (gen_count !== 16'd1 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset got gen=%0d run=%b exp 1 1",
               gen_count, running);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_tests++;
    if (state_o !== IDLE || gen_count !== 16'd0 || clr !== 1'b1 ||
        advance !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset got st=%0d gen=%0d clr=%b exp 0 0 1",
               state_o, gen_count, clr);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; randomize = 1'b0;
    pause = 1'b0; step = 1'b0; clear = 1'b0;
    speed = '0; max_gen = '0;
    test_reset();
    test_seed();
    test_play();
    test_pause_step();
    test_maxgen();
    test_speed_drop();
    test_clear_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Parametrised successor to the board control FSM. Sequences the cellular-automaton board through clear, random seeding, free-running play, pause/single-step and a generation-limit stop.
- Adds on-chip button edge detection, a programmable generation-rate divider, a generation counter and a soft clear.
- Sits between the board-level button inputs and the LFSR seeder and board-update logic.

Parameters:
- GEN_W, 16, width of the generation counter and of max_gen.
- DIV_W, 24, width of the rate divider and of speed.
- SEED_CYCLES, 64, number of cycles rnd_en is held high per seeding pass (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (reset==0 at a posedge resets the block).
- start  in  1  level button; rising edge acts.
- randomize  in  1  level button; rising edge acts.
- pause  in  1  level button; rising edge toggles between play and pause.
- step  in  1  level button; rising edge advances one generation while paused.
- clear  in  1  level; while high, forces return to IDLE.
- speed  in  DIV_W  advance period minus 1, in cycles.
- max_gen  in  GEN_W  generation limit; 0 = unlimited.
- clr  out  1  board clear enable.
- rnd_en  out  1  LFSR seed enable.
- advance  out  1  one-cycle pulse: compute the next generation.
- running  out  1  state==PLAY.
- done  out  1  state==DONE.
- gen_count  out  GEN_W  generations advanced since the last start or seed.
- state_o  out  3  current state encoding.

Behaviour:
- Reset:
  - state=IDLE, div=0, seed counter=0, gen_count=0, advance=0.
  - Button-history registers are set to 1, so a button held through reset produces no edge.
  - After reset: clr=1, all other outputs 0.
- Edge detect: x_p = x & ~x_prev, registered history per button. A pulse is acted on in the same cycle it is detected.
- Moore outputs:
  - clr = (IDLE)
  - rnd_en = (SEED)
  - running = (PLAY)
  - done = (DONE)
- advance and gen_count are registered and update on the same edge.
- Event priority, every state: clear > randomize_p > start_p / pause_p > step_p.
- clear=1: next state IDLE, div=0, advance=0. gen_count is preserved until the next start/seed.
- IDLE:
  - randomize_p → SEED.
  - start_p → PLAY, gen_count=0, div=0.
- SEED:
  - Seed counter runs 0..SEED_CYCLES-1. On the last count → PAUSE; rnd_en is high exactly SEED_CYCLES cycles.
  - gen_count=0 on entry.
  - start_p, pause_p and step_p are ignored.
  - randomize_p restarts the seed counter.
- PLAY:
  - Each cycle, if div ≥ speed: advance←1, div←0, gen_count←gen_count+1 (saturating at all-ones). Otherwise div←div+1.
  - With speed=0, advance is high every cycle.
  - First advance occurs speed+1 cycles after entering PLAY.
  - If max_gen≠0 and an advance makes gen_count==max_gen → DONE on the same edge.
  - pause_p → PAUSE, div held.
  - randomize_p → SEED.
  - A speed change takes effect on the next comparison; the ≥ compare prevents a stall when speed drops below div.
- PAUSE:
  - start_p or pause_p → PLAY; div resumes from its held value.
  - step_p → advance←1 for one cycle and gen_count+1, remaining in PAUSE. The max_gen check also applies (→ DONE).
  - randomize_p → SEED.
- DONE:
  - advance=0.
  - start_p → PLAY, gen_count=0, div=0.
  - randomize_p → SEED.
  - Other buttons are ignored.
- advance deasserts on the edge after it was set unless re-triggered (speed=0).
- reset low mid-operation overrides everything, with the same result as power-up reset.

Decomposition:
- Package game_pkg:
  - typedef enum logic [2:0] {IDLE, SEED, PLAY, PAUSE, DONE} game_state_t.
  - Default parameter constants.
- Sub-module edge_detect #(N):
  - Per-bit rising-edge pulse with synchronous active-low reset, history set to 1.
  - Instantiated once with N=4 for start, randomize, pause and step.

Test Plan:
- Hold start=1 while reset=0, release reset, keep start=1 for 10 cycles → stays IDLE, clr=1, no advance.
- IDLE, SEED_CYCLES=4, pulse randomize → rnd_en high exactly 4 cycles, then state_o=PAUSE, gen_count=0.
- Pulse start, speed=3, max_gen=0 → advance pulses at cycles 4, 8, 12 after PLAY entry; gen_count 1, 2, 3.
- speed=0, max_gen=5, pulse start → 5 consecutive advance cycles, then done=1, gen_count=5, no further advance.
- In PLAY pulse pause, then two step pulses 10 cycles apart → exactly two advance pulses, gen_count+2, state stays PAUSE; pulse pause again → PLAY.
- In PLAY, assert clear and randomize in the same cycle → IDLE (clear wins). Then pull reset low mid-PLAY → IDLE, gen_count=0, clr=1.
